// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core with one shared request/acknowledge memory port,
// so memories may insert wait states. It has a memory-mapped 8-bit input port
// and a 32-bit output register at IO_BASE.
// When MIPS_JAL_JR_EN is defined, the core also executes jal and jr.
// Otherwise jal and jr are treated as unsupported opcodes and stop the core.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   PortIn[7:0]      input port; a lw from IO_BASE returns it zero-extended
//   mem_req/mem_we   memory request and write strobe (we is valid only with req)
//   mem_addr/wdata   word-aligned byte address and store data
//   mem_rdata/ack    read data and completion of the current request
//   PortOut          last value stored to IO_BASE
//   ALUResultOut     ALUOut register
//   halted           sticky flag, set by an unsupported opcode
module mips_multicycle_core #(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter logic [31:0] IO_BASE      = 32'h1001_0024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  PortIn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] PortOut,
  output logic [31:0] ALUResultOut,
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_JAL_JR_EN
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
`endif

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, RWB, IWB, LWB, HALT} state_t;

  state_t state, nextState;

  logic [XLEN-1:0] pc, ir, regA, regB, aluOut, mdr;
  logic [XLEN-1:0] regs [32];

  // Instruction fields
  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd, shamt;
  logic [25:0]     target;
  logic [XLEN-1:0] immSext, immZext;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign target  = ir[25:0];
  assign immSext = {{16{ir[15]}}, ir[15:0]};
  assign immZext = {16'h0000, ir[15:0]};

  // Data-access classification, evaluated in MEM from the address held in ALUOut
  logic isIo, inRange, dataBypass, isSw;
  assign isIo       = (aluOut == IO_BASE);
  assign inRange    = ({2'b00, aluOut} < (34'(MEMORY_DEPTH) << 2));
  assign dataBypass = isIo || !inRange;
  assign isSw       = (opcode == OP_SW);

`ifdef MIPS_JAL_JR_EN
  logic isJr;
  assign isJr = (opcode == OP_RTYPE) && (funct == FN_JR);
`endif

  // Opcode/funct legality check used in DECODE
  logic opSupported;
  always_comb begin
    opSupported = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: opSupported = 1'b1;
`ifdef MIPS_JAL_JR_EN
          FN_JR: opSupported = 1'b1;
`endif
          default: opSupported = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: opSupported = 1'b1;
`ifdef MIPS_JAL_JR_EN
      OP_JAL: opSupported = 1'b1;
`endif
      default: opSupported = 1'b0;
    endcase
  end

  // R-type ALU
  logic [XLEN-1:0] rResult;
  always_comb begin
    case (funct)
      FN_ADD:  rResult = regA + regB;
      FN_SUB:  rResult = regA - regB;
      FN_AND:  rResult = regA & regB;
      FN_OR:   rResult = regA | regB;
      FN_NOR:  rResult = ~(regA | regB);
      FN_SLL:  rResult = regB << shamt;
      FN_SRL:  rResult = regB >> shamt;
      default: rResult = '0;
    endcase
  end

  // Control signals produced by the FSM for the datapath
  logic            pcWrite, irWrite, abWrite, aluWrite, mdrWrite, regWrite, portWrite, haltSet;
  logic [XLEN-1:0] pcNext, aluNext, mdrNext, regWdata, memAddrC;
  logic [4:0]      regWaddr;
  logic            memReqC, memWeC;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Next state and datapath control
  always_comb begin
    nextState = state;
    pcWrite   = 1'b0;
    pcNext    = pc;
    irWrite   = 1'b0;
    abWrite   = 1'b0;
    aluWrite  = 1'b0;
    aluNext   = aluOut;
    mdrWrite  = 1'b0;
    mdrNext   = mdr;
    regWrite  = 1'b0;
    regWaddr  = 5'd0;
    regWdata  = aluOut;
    portWrite = 1'b0;
    haltSet   = 1'b0;
    memReqC   = 1'b0;
    memWeC    = 1'b0;
    memAddrC  = pc;
    case (state)
      FETCH: begin
        memReqC = 1'b1;
        if (mem_ack) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          pcNext    = pc + 32'd4;
          nextState = DECODE;
        end
      end
      DECODE: begin
        // Branch target is computed here so EXEC only has to compare
        abWrite  = 1'b1;
        aluWrite = 1'b1;
        aluNext  = pc + (immSext << 2);
        if (opSupported) begin
          nextState = EXEC;
        end else begin
          nextState = HALT;
          haltSet   = 1'b1;
        end
      end
      EXEC: begin
        nextState = FETCH;
        case (opcode)
          OP_RTYPE: begin
            aluWrite  = 1'b1;
            aluNext   = rResult;
`ifdef MIPS_JAL_JR_EN
            if (isJr) aluNext = regA;
`endif
            nextState = RWB;
          end
          OP_ADDI: begin
            aluWrite  = 1'b1;
            aluNext   = regA + immSext;
            nextState = IWB;
          end
          OP_ORI: begin
            aluWrite  = 1'b1;
            aluNext   = regA | immZext;
            nextState = IWB;
          end
          OP_LW, OP_SW: begin
            aluWrite  = 1'b1;
            aluNext   = regA + immSext;
            nextState = MEM;
          end
          OP_BEQ: begin
            pcWrite = (regA == regB);
            pcNext  = aluOut;
          end
          OP_BNE: begin
            pcWrite = (regA != regB);
            pcNext  = aluOut;
          end
          OP_J: begin
            pcWrite = 1'b1;
            pcNext  = {pc[31:28], target, 2'b00};
          end
`ifdef MIPS_JAL_JR_EN
          OP_JAL: begin
            // pc already points past the jal, which is the return address
            regWrite = 1'b1;
            regWaddr = 5'd31;
            regWdata = pc;
            pcWrite  = 1'b1;
            pcNext   = {pc[31:28], target, 2'b00};
          end
`endif
          default: begin
            nextState = HALT;
            haltSet   = 1'b1;
          end
        endcase
      end
      MEM: begin
        memAddrC = aluOut;
        if (dataBypass) begin
          // I/O or out-of-range access completes locally without touching the port
          if (isSw) begin
            portWrite = isIo;
            nextState = FETCH;
          end else begin
            mdrWrite  = 1'b1;
            mdrNext   = isIo ? {24'h000000, PortIn} : '0;
            nextState = LWB;
          end
        end else begin
          memReqC = 1'b1;
          memWeC  = isSw;
          if (mem_ack) begin
            if (isSw) begin
              nextState = FETCH;
            end else begin
              mdrWrite  = 1'b1;
              mdrNext   = mem_rdata;
              nextState = LWB;
            end
          end
        end
      end
      RWB: begin
        nextState = FETCH;
`ifdef MIPS_JAL_JR_EN
        if (isJr) begin
          pcWrite = 1'b1;
          pcNext  = aluOut;
        end else begin
          regWrite = 1'b1;
          regWaddr = rd;
        end
`else
        regWrite = 1'b1;
        regWaddr = rd;
`endif
      end
      IWB: begin
        regWrite  = 1'b1;
        regWaddr  = rt;
        nextState = FETCH;
      end
      LWB: begin
        regWrite  = 1'b1;
        regWaddr  = rt;
        regWdata  = mdr;
        nextState = FETCH;
      end
      HALT: nextState = HALT;
      default: nextState = HALT;
    endcase
  end

  // Datapath registers and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      regA    <= '0;
      regB    <= '0;
      aluOut  <= '0;
      mdr     <= '0;
      PortOut <= '0;
      halted  <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (pcWrite)   pc      <= pcNext;
      if (irWrite)   ir      <= mem_rdata;
      if (abWrite) begin
        regA <= regs[rs];
        regB <= regs[rt];
      end
      if (aluWrite)  aluOut  <= aluNext;
      if (mdrWrite)  mdr     <= mdrNext;
      if (portWrite) PortOut <= regB;
      if (haltSet)   halted  <= 1'b1;
      // $0 is never written, so it always reads as zero
      if (regWrite && (regWaddr != 5'd0)) regs[regWaddr] <= regWdata;
    end
  end

  // The memory strobes are gated by reset so an in-flight access drops at once
  assign mem_req      = memReqC && !reset;
  assign mem_we       = memWeC && !reset;
  assign mem_addr     = memAddrC & ~32'h0000_0003;
  assign mem_wdata    = regB;
  assign ALUResultOut = aluOut;

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] IO_BASE  = 32'h1001_0024;
`ifdef MIPS_JAL_JR_EN
  localparam int HALT_IDX = 26;
`else
  localparam int HALT_IDX = 24;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PortIn;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] PortOut, ALUResultOut;
  logic        halted;

  mips_multicycle_core dut (
    .clk(clk), .reset(reset), .PortIn(PortIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .PortOut(PortOut), .ALUResultOut(ALUResultOut), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory model: program at RESET_PC (zero-wait), data at 0..0x3FF (dataDelay waits)
  logic [31:0] progMem [0:127];
  logic [31:0] dataMem [0:255];
  int          dataDelay;
  int          waitCnt;
  logic        holdAck;

  function automatic logic isProg(input logic [31:0] a);
    return a[31:9] == 23'h002000;
  endfunction

  always_comb begin
    if (isProg(mem_addr)) mem_rdata = progMem[mem_addr[8:2]];
    else                  mem_rdata = dataMem[mem_addr[9:2]];
    mem_ack = !holdAck && mem_req && (isProg(mem_addr) || waitCnt >= dataDelay);
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ack && !isProg(mem_addr)) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
    if (mem_req && mem_ack && mem_we && !isProg(mem_addr)) dataMem[mem_addr[9:2]] <= mem_wdata;
  end

  // Encoders
  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [31:0] a);
    return {op, a[27:2]};
  endfunction

  localparam logic [4:0] T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, T3 = 5'd11, T4 = 5'd12;
  localparam logic [4:0] S0 = 5'd16, S1 = 5'd17, RA = 5'd31;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Results of the last runInstr call
  int          rCyc, rDataCyc;
  logic        rStable, rWe;
  logic [31:0] rDAddr, rDWdata, rFAddr;

  // Runs from one fetch cycle to the next, recording data-port activity on the way
  task automatic runInstr();
    rCyc = 0; rDataCyc = 0; rStable = 1'b1; rWe = 1'b0; rDAddr = '0; rDWdata = '0;
    do begin
      @(negedge clk);
      rCyc++;
      if (mem_req && !isProg(mem_addr)) begin
        if (rDataCyc == 0) begin
          rDAddr = mem_addr; rDWdata = mem_wdata; rWe = mem_we;
        end else if (mem_addr !== rDAddr || mem_wdata !== rDWdata || mem_we !== rWe) begin
          rStable = 1'b0;
        end
        rDataCyc++;
      end
    end while (!(mem_req && !mem_we && isProg(mem_addr)) && rCyc < 100);
    rFAddr = mem_addr;
  endtask

  task automatic step(input string name, input int expCyc, input logic [31:0] expAlu,
                      input logic [31:0] expAddr);
    runInstr();
    check({name, "_cycles"}, 32'(rCyc), 32'(expCyc));
    check({name, "_alu"}, ALUResultOut, expAlu);
    check({name, "_next_pc"}, rFAddr, expAddr);
  endtask

  task automatic waitHalt(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 20);
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_latency"}, 32'(n), 32'd2);
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] alu;
    int          cyc;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    int reqSeen;

    vecs[0]  = '{"addi_5",    encI(6'h08, 5'd0, T0, 16'd5),        32'h0000_0005, 4};
    vecs[1]  = '{"addi_m3",   encI(6'h08, 5'd0, T1, 16'hFFFD),     32'hFFFF_FFFD, 4};
    vecs[2]  = '{"add",       encR(T0, T1, T2, 5'd0, 6'h20),       32'h0000_0002, 4};
    vecs[3]  = '{"nor",       encR(T2, 5'd0, T3, 5'd0, 6'h27),     32'hFFFF_FFFD, 4};
    vecs[4]  = '{"sub",       encR(T1, T0, T4, 5'd0, 6'h22),       32'hFFFF_FFF8, 4};
    vecs[5]  = '{"and",       encR(T3, T0, T4, 5'd0, 6'h24),       32'h0000_0005, 4};
    vecs[6]  = '{"or",        encR(T2, T0, T4, 5'd0, 6'h25),       32'h0000_0007, 4};
    vecs[7]  = '{"sll",       encR(5'd0, T0, T4, 5'd4, 6'h00),     32'h0000_0050, 4};
    vecs[8]  = '{"srl",       encR(5'd0, T1, T4, 5'd28, 6'h02),    32'h0000_000F, 4};
    vecs[9]  = '{"ori_s0",    encI(6'h0D, 5'd0, S0, 16'h0100),     32'h0000_0100, 4};
    vecs[10] = '{"ori_zext",  encI(6'h0D, 5'd0, T4, 16'h8000),     32'h0000_8000, 4};
    vecs[11] = '{"addi_sext", encI(6'h08, 5'd0, T4, 16'h8000),     32'hFFFF_8000, 4};

    for (int i = 0; i < 128; i++) progMem[i] = 32'hFC00_0000;
    for (int i = 0; i < 256; i++) dataMem[i] = '0;
    for (int i = 0; i < NV; i++) progMem[i] = vecs[i].instr;
    progMem[12] = encI(6'h2B, S0, T0, 16'd0);          // sw $t0,0($s0)
    progMem[13] = encI(6'h23, S0, T4, 16'd0);          // lw $t4,0($s0)
    progMem[14] = encI(6'h08, T4, T4, 16'd0);          // addi $t4,$t4,0
    progMem[15] = encI(6'h0D, 5'd0, S1, 16'h1001);     // ori $s1,$0,0x1001
    progMem[16] = encR(5'd0, S1, S1, 5'd16, 6'h00);    // sll $s1,$s1,16
    progMem[17] = encI(6'h0D, S1, S1, 16'h0024);       // ori $s1,$s1,0x24
    progMem[18] = encI(6'h23, S1, T4, 16'd0);          // lw $t4,0($s1)  (I/O)
    progMem[19] = encI(6'h08, T4, T4, 16'd0);          // addi $t4,$t4,0
    progMem[20] = encI(6'h0D, 5'd0, T1, 16'h1234);     // ori $t1,$0,0x1234
    progMem[21] = encI(6'h2B, S1, T1, 16'd0);          // sw $t1,0($s1)  (I/O)
    progMem[22] = encI(6'h05, 5'd0, 5'd0, 16'd4);      // bne $0,$0,+4
    progMem[23] = encI(6'h04, 5'd0, 5'd0, 16'hFFFF);   // beq $0,$0,-1
`ifdef MIPS_JAL_JR_EN
    progMem[24] = encJ(6'h03, RESET_PC + 32'h180);     // jal word 96
    progMem[25] = encI(6'h08, RA, T4, 16'd0);          // addi $t4,$ra,0
    progMem[96] = encR(RA, 5'd0, 5'd0, 5'd0, 6'h08);   // jr $ra
`endif
    progMem[HALT_IDX] = 32'hFC00_0000;                 // opcode 0x3F

    // Reset state and reset during a stalled fetch
    reset = 1'b1; holdAck = 1'b1; dataDelay = 0; PortIn = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_alu", ALUResultOut, 32'h0);
    check("rst_portout", PortOut, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    #1;
    check("fetch_req", 32'(mem_req), 32'd1);
    check("fetch_addr", mem_addr, RESET_PC);
    @(posedge clk); #2;
    check("fetch_stall_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_drops_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    holdAck = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, RESET_PC);

    // Table of ALU instructions with zero-wait memory
    for (int i = 0; i < NV; i++)
      step(vecs[i].name, vecs[i].cyc, vecs[i].alu, RESET_PC + 32'(4 * (i + 1)));

    // Store and load with three wait states
    dataDelay = 3;
    step("sw_wait", 7, 32'h100, RESET_PC + 32'd52);
    check("sw_data_cycles", 32'(rDataCyc), 32'd4);
    check("sw_stable", 32'(rStable), 32'd1);
    check("sw_we", 32'(rWe), 32'd1);
    check("sw_addr", rDAddr, 32'h100);
    check("sw_wdata", rDWdata, 32'd5);
    check("sw_mem", dataMem[64], 32'd5);
    step("lw_wait", 8, 32'h100, RESET_PC + 32'd56);
    check("lw_data_cycles", 32'(rDataCyc), 32'd4);
    check("lw_we", 32'(rWe), 32'd0);
    dataDelay = 0;
    step("lw_result", 4, 32'd5, RESET_PC + 32'd60);

    // Memory-mapped I/O
    PortIn = 8'hA5;
    step("io_base_hi", 4, 32'h0000_1001, RESET_PC + 32'd64);
    step("io_base_sll", 4, 32'h1001_0000, RESET_PC + 32'd68);
    step("io_base", 4, IO_BASE, RESET_PC + 32'd72);
    step("io_lw", 5, IO_BASE, RESET_PC + 32'd76);
    check("io_lw_no_req", 32'(rDataCyc), 32'd0);
    step("io_lw_result", 4, 32'h0000_00A5, RESET_PC + 32'd80);
    step("io_val", 4, 32'h0000_1234, RESET_PC + 32'd84);
    step("io_sw", 4, IO_BASE, RESET_PC + 32'd88);
    check("io_sw_no_req", 32'(rDataCyc), 32'd0);
    check("io_portout", PortOut, 32'h0000_1234);

    // Branches: bne falls through, beq loops on itself
    step("bne_not_taken", 3, RESET_PC + 32'h6C, RESET_PC + 32'h5C);
    step("beq_loop1", 3, RESET_PC + 32'h5C, RESET_PC + 32'h5C);
    step("beq_loop2", 3, RESET_PC + 32'h5C, RESET_PC + 32'h5C);
    progMem[23] = encJ(6'h02, RESET_PC + 32'h60);       // break the loop
    runInstr();
    check("j_cycles", 32'(rCyc), 32'd3);
    check("j_next_pc", rFAddr, RESET_PC + 32'h60);

`ifdef MIPS_JAL_JR_EN
    runInstr();
    check("jal_cycles", 32'(rCyc), 32'd3);
    check("jal_next_pc", rFAddr, RESET_PC + 32'h180);
    step("jr", 4, RESET_PC + 32'h64, RESET_PC + 32'h64);
    step("ra_value", 4, RESET_PC + 32'h64, RESET_PC + 32'h68);
`endif

    // Unsupported opcode 0x3F
    waitHalt("op3f");
    reqSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) reqSeen++;
    end
    check("halt_no_req", 32'(reqSeen), 32'd0);
    check("halt_sticky", 32'(halted), 32'd1);

    reset = 1'b1;
    #1;
    check("rst_clears_halt", 32'(halted), 32'd0);
`ifndef MIPS_JAL_JR_EN
    // Without the option, jr is an unsupported instruction
    progMem[0] = encR(RA, 5'd0, 5'd0, 5'd0, 6'h08);
    @(negedge clk);
    reset = 1'b0;
    waitHalt("jr_disabled");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
